// File: rtl/axis_dword_framer.sv
// Frames dword-aligned read data into a byte-qualified AXI-Stream packet.
// A command selects a byte window; tkeep marks valid lanes and tlast the final dword.
module axis_dword_framer #(
    parameter string BIG_ENDIAN = "TRUE"
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic [1:0]  cmd_src_off_i,
    input  logic [15:0] cmd_len_i,
    input  logic [1:0]  cmd_dst_off_i,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic [31:0] d_tdata_i,
    input  logic        d_tvalid_i,
    output logic        d_tready_o,
    output logic [31:0] m_tdata_o,
    output logic [3:0]  m_tkeep_o,
    output logic        m_tlast_o,
    output logic [1:0]  m_tuser_o,
    output logic        m_tvalid_o,
    input  logic        m_tready_i
);

    localparam bit BigEnd = (BIG_ENDIAN == "TRUE");

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    state_e      state_q;
    logic [14:0] cnt_q;
    logic        first_q;
    logic [1:0]  src_off_q;
    logic [1:0]  dst_off_q;
    logic [1:0]  end_off_q;
    logic [31:0] m_tdata_q;
    logic [3:0]  m_tkeep_q;
    logic        m_tlast_q;
    logic [1:0]  m_tuser_q;
    logic        m_tvalid_q;

    logic [16:0] span_sum;
    logic [14:0] cmd_words;
    logic [1:0]  cmd_end_off;
    logic        d_hs;
    logic        m_hs;
    logic        last_word;
    logic [3:0]  first_mask;
    logic [3:0]  last_mask;
    logic [3:0]  keep_be;
    logic [3:0]  keep_lane;

    always_comb begin
        span_sum    = {15'd0, cmd_src_off_i} + {1'b0, cmd_len_i} + 17'd3;
        cmd_words   = span_sum[16:2];
        // (src + len) & 3 recovered from the rounded-up sum.
        cmd_end_off = span_sum[1:0] + 2'd1;

        cmd_ready_o = (state_q == StIdle);
        d_tready_o  = (state_q == StBusy) && (!m_tvalid_q || m_tready_i);
        d_hs        = d_tvalid_i && d_tready_o;
        m_hs        = m_tvalid_q && m_tready_i;
        last_word   = (cnt_q == 15'd1);

        first_mask = 4'b1111;
        unique case (src_off_q)
            2'd0: first_mask = 4'b1111;
            2'd1: first_mask = 4'b0111;
            2'd2: first_mask = 4'b0011;
            2'd3: first_mask = 4'b0001;
            default: first_mask = 4'b1111;
        endcase

        last_mask = 4'b1111;
        unique case (end_off_q)
            2'd0: last_mask = 4'b1111;
            2'd1: last_mask = 4'b1000;
            2'd2: last_mask = 4'b1100;
            2'd3: last_mask = 4'b1110;
            default: last_mask = 4'b1111;
        endcase

        keep_be   = (first_q ? first_mask : 4'b1111) & (last_word ? last_mask : 4'b1111);
        keep_lane = BigEnd ? keep_be : {keep_be[0], keep_be[1], keep_be[2], keep_be[3]};
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            first_q    <= 1'b0;
            src_off_q  <= '0;
            dst_off_q  <= '0;
            end_off_q  <= '0;
            m_tdata_q  <= '0;
            m_tkeep_q  <= '0;
            m_tlast_q  <= 1'b0;
            m_tuser_q  <= '0;
            m_tvalid_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    // Zero-length commands are consumed here without leaving IDLE.
                    if (cmd_valid_i && (cmd_len_i != 16'd0)) begin
                        src_off_q <= cmd_src_off_i;
                        dst_off_q <= cmd_dst_off_i;
                        end_off_q <= cmd_end_off;
                        cnt_q     <= cmd_words;
                        first_q   <= 1'b1;
                        state_q   <= StBusy;
                    end
                end
                StBusy: begin
                    if (d_hs) begin
                        cnt_q   <= cnt_q - 15'd1;
                        first_q <= 1'b0;
                        if (last_word) begin
                            state_q <= StIdle;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase

            if (d_hs) begin
                m_tdata_q  <= d_tdata_i;
                m_tkeep_q  <= keep_lane;
                m_tlast_q  <= last_word;
                m_tuser_q  <= dst_off_q;
                m_tvalid_q <= 1'b1;
            end else if (m_hs) begin
                m_tvalid_q <= 1'b0;
            end
        end
    end

    assign m_tdata_o  = m_tdata_q;
    assign m_tkeep_o  = m_tkeep_q;
    assign m_tlast_o  = m_tlast_q;
    assign m_tuser_o  = m_tuser_q;
    assign m_tvalid_o = m_tvalid_q;

endmodule

// File: tb/tb_axis_dword_framer.sv
// Bench for axis_dword_framer: big- and little-endian instances share stimulus and are
// checked against a byte-window model of the packet.
module tb_axis_dword_framer;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic [1:0]  cmd_src_off;
    logic [15:0] cmd_len;
    logic [1:0]  cmd_dst_off;
    logic        cmd_valid;
    logic [31:0] d_tdata;
    logic        d_tvalid;
    logic        m_tready;

    logic        be_cmd_ready, be_d_tready, be_m_tlast, be_m_tvalid;
    logic [31:0] be_m_tdata;
    logic [3:0]  be_m_tkeep;
    logic [1:0]  be_m_tuser;
    logic        le_cmd_ready, le_d_tready, le_m_tlast, le_m_tvalid;
    logic [31:0] le_m_tdata;
    logic [3:0]  le_m_tkeep;
    logic [1:0]  le_m_tuser;

    int checks   = 0;
    int failures = 0;

    always #5 aclk = ~aclk;

    axis_dword_framer u_be (
        .aclk         (aclk),
        .aresetn      (aresetn),
        .cmd_src_off_i(cmd_src_off),
        .cmd_len_i    (cmd_len),
        .cmd_dst_off_i(cmd_dst_off),
        .cmd_valid_i  (cmd_valid),
        .cmd_ready_o  (be_cmd_ready),
        .d_tdata_i    (d_tdata),
        .d_tvalid_i   (d_tvalid),
        .d_tready_o   (be_d_tready),
        .m_tdata_o    (be_m_tdata),
        .m_tkeep_o    (be_m_tkeep),
        .m_tlast_o    (be_m_tlast),
        .m_tuser_o    (be_m_tuser),
        .m_tvalid_o   (be_m_tvalid),
        .m_tready_i   (m_tready)
    );

    axis_dword_framer #(.BIG_ENDIAN("FALSE")) u_le (
        .aclk         (aclk),
        .aresetn      (aresetn),
        .cmd_src_off_i(cmd_src_off),
        .cmd_len_i    (cmd_len),
        .cmd_dst_off_i(cmd_dst_off),
        .cmd_valid_i  (cmd_valid),
        .cmd_ready_o  (le_cmd_ready),
        .d_tdata_i    (d_tdata),
        .d_tvalid_i   (d_tvalid),
        .d_tready_o   (le_d_tready),
        .m_tdata_o    (le_m_tdata),
        .m_tkeep_o    (le_m_tkeep),
        .m_tlast_o    (le_m_tlast),
        .m_tuser_o    (le_m_tuser),
        .m_tvalid_o   (le_m_tvalid),
        .m_tready_i   (m_tready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Byte at packet position 4*k+i is valid when it lies in [src, src+len).
    function automatic logic [3:0] model_keep(input int src, input int len, input int k,
                                              input bit be);
        logic [3:0] keep;
        int pos;
        keep = '0;
        for (int i = 0; i < 4; i++) begin
            pos = 4 * k + i;
            if (be) keep[3-i] = (pos >= src) && (pos < src + len);
            else    keep[i]   = (pos >= src) && (pos < src + len);
        end
        return keep;
    endfunction

    task automatic send_cmd(input int src, input int len, input int dst);
        @(negedge aclk);
        cmd_src_off = 2'(src);
        cmd_len     = 16'(len);
        cmd_dst_off = 2'(dst);
        cmd_valid   = 1'b1;
        #1;
        chk("cmd_ready_idle", {31'd0, be_cmd_ready}, 32'd1);
        @(negedge aclk);
        cmd_valid = 1'b0;
    endtask

    // mode 0: m_tready held high; 1: random ready/valid; 2: 1,0,0,1 pattern plus a low stretch.
    task automatic run_pkt(input int src, input int len, input int dst, input int mode);
        logic [31:0] data[$];
        int  words;
        int  d_idx;
        int  m_idx;
        int  cyc;
        int  bound;
        bit  prev_d;
        words = (src + len + 3) / 4;
        for (int k = 0; k < words; k++) data.push_back($urandom);
        send_cmd(src, len, dst);
        if (len == 0) begin
            d_tvalid = 1'b1;
            d_tdata  = $urandom;
            #1;
            chk("zero_len_cmd_ready", {31'd0, be_cmd_ready}, 32'd1);
            chk("zero_len_no_valid", {31'd0, be_m_tvalid}, 32'd0);
            chk("idle_d_ready", {31'd0, be_d_tready}, 32'd0);
            d_tvalid = 1'b0;
            return;
        end
        d_idx  = 0;
        m_idx  = 0;
        cyc    = 0;
        prev_d = 1'b0;
        bound  = 100 + 10 * words;
        while (m_idx < words && cyc < bound) begin
            if (mode == 0)      m_tready = 1'b1;
            else if (mode == 1) m_tready = 1'($urandom_range(0, 1));
            else if (cyc >= 8 && cyc < 13) m_tready = 1'b0;
            else m_tready = (cyc % 4 == 0) || (cyc % 4 == 3);
            d_tvalid = (d_idx < words) && (mode != 1 || $urandom_range(0, 3) != 0);
            d_tdata  = (d_idx < words) ? data[d_idx] : $urandom;
            #1;
            if (cyc == 0 && mode == 0) chk("first_d_ready", {31'd0, be_d_tready}, 32'd1);
            if (prev_d) chk("m_valid_after_d", {31'd0, be_m_tvalid}, 32'd1);
            if (be_m_tvalid && !m_tready) chk("d_ready_backpressure", {31'd0, be_d_tready}, 32'd0);
            if (be_m_tvalid) chk("keep_nonzero", {31'd0, be_m_tkeep != 4'd0}, 32'd1);
            chk("cmd_ready_busy", {31'd0, be_cmd_ready}, {31'd0, d_idx == words});
            prev_d = d_tvalid && be_d_tready;
            if (be_m_tvalid && m_tready) begin
                chk("be_tdata", be_m_tdata, data[m_idx]);
                chk("le_tdata", le_m_tdata, data[m_idx]);
                chk("be_tkeep", {28'd0, be_m_tkeep}, {28'd0, model_keep(src, len, m_idx, 1'b1)});
                chk("le_tkeep", {28'd0, le_m_tkeep}, {28'd0, model_keep(src, len, m_idx, 1'b0)});
                chk("tlast", {30'd0, le_m_tlast, be_m_tlast},
                    {30'd0, {2{m_idx == words - 1}}});
                chk("tuser", {28'd0, le_m_tuser, be_m_tuser}, {28'd0, 2'(dst), 2'(dst)});
                chk("le_tvalid", {31'd0, le_m_tvalid}, 32'd1);
                m_idx++;
            end
            if (prev_d) d_idx++;
            @(negedge aclk);
            cyc++;
        end
        chk("beat_count", m_idx, words);
        d_tvalid = 1'b0;
        m_tready = 1'b1;
        #1;
        chk("post_pkt_cmd_ready", {31'd0, be_cmd_ready}, 32'd1);
        chk("post_pkt_m_valid", {31'd0, be_m_tvalid}, 32'd0);
    endtask

    initial begin
        aresetn     = 1'b0;
        cmd_src_off = '0;
        cmd_len     = '0;
        cmd_dst_off = '0;
        cmd_valid   = 1'b0;
        d_tdata     = '0;
        d_tvalid    = 1'b0;
        m_tready    = 1'b1;
        #2;
        chk("rst_m_tvalid", {31'd0, be_m_tvalid}, 32'd0);
        chk("rst_m_tlast", {31'd0, be_m_tlast}, 32'd0);
        chk("rst_m_tkeep", {28'd0, be_m_tkeep}, 32'd0);
        chk("rst_m_tdata", be_m_tdata, 32'd0);
        chk("rst_m_tuser", {30'd0, be_m_tuser}, 32'd0);
        chk("rst_cmd_ready", {31'd0, be_cmd_ready}, 32'd1);
        chk("rst_d_tready", {31'd0, be_d_tready}, 32'd0);
        @(negedge aclk);
        aresetn = 1'b1;

        run_pkt(0, 8, 0, 0);   // aligned
        run_pkt(1, 2, 0, 0);   // single word, keep 0110
        run_pkt(3, 6, 2, 0);   // spanning, keep 0001/1111/1000
        run_pkt(2, 64, 1, 2);  // backpressure, 17 beats
        run_pkt(0, 0, 3, 0);   // zero length
        run_pkt(0, 4, 1, 0);   // back-to-back single word

        // Reset during beat 3 of a 10-word packet.
        send_cmd(0, 40, 1);
        m_tready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            d_tvalid = 1'b1;
            d_tdata  = $urandom;
            @(negedge aclk);
        end
        d_tvalid = 1'b0;
        #1;
        chk("beat3_valid", {31'd0, be_m_tvalid}, 32'd1);
        aresetn = 1'b0;
        #1;
        chk("mid_rst_m_tvalid", {30'd0, le_m_tvalid, be_m_tvalid}, 32'd0);
        chk("mid_rst_m_tlast", {31'd0, be_m_tlast}, 32'd0);
        chk("mid_rst_cmd_ready", {31'd0, be_cmd_ready}, 32'd1);
        @(negedge aclk);
        aresetn = 1'b1;
        #1;
        chk("post_rst_cmd_ready", {31'd0, be_cmd_ready}, 32'd1);
        chk("post_rst_m_tvalid", {31'd0, be_m_tvalid}, 32'd0);
        run_pkt(1, 2, 0, 0);   // little-endian keep 0110 after reset

        for (int n = 0; n < 12; n++) begin
            run_pkt($urandom_range(0, 3),
                    ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 40),
                    $urandom_range(0, 3), $urandom_range(0, 2));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axis_dword_framer.md
# axis_dword_framer

Converts dword-aligned host-memory read data into a byte-qualified AXI-Stream packet for the transmit path. Accepts a per-packet command (source byte offset, byte length, destination offset), consumes exactly the dwords covering that byte range, and marks valid bytes with tkeep and the last dword with tlast. Feeds axis_realign directly; m_tuser carries the destination offset axis_realign uses for lane masking.

## Interface
- BIG_ENDIAN, "TRUE": "TRUE" maps the lowest-address byte to tdata[31:24]/tkeep[3]; otherwise to tdata[7:0]/tkeep[0]. The same setting applies to d_tdata and m_tdata.
- aclk  in  1  clock
- aresetn  in  1  reset, asynchronous, active-low
- cmd_src_off  in  2  byte offset of the first valid byte within the first dword
- cmd_len  in  16  packet length in bytes; 0 is legal
- cmd_dst_off  in  2  destination offset, forwarded on m_tuser
- cmd_valid  in  1  command valid
- cmd_ready  out  1  command ready (high in IDLE)
- d_tdata  in  32  dword-aligned read data
- d_tvalid  in  1  read data valid
- d_tready  out  1  read data ready
- m_tdata  out  32  output data (d_tdata passed unmodified)
- m_tkeep  out  4  byte qualifiers
- m_tlast  out  1  last dword of packet
- m_tuser  out  2  destination offset, constant for the whole packet
- m_tvalid  out  1  output valid
- m_tready  in  1  output ready

## Operation
- The FSM has two states: IDLE and BUSY. cmd_ready = (state == IDLE).
- **IDLE, cmd_valid, cmd_len ≠ 0:**
  - Latch src_off and dst_off.
  - Load words = (src_off + len + 3) >> 2 into a 15-bit counter (maximum 16385).
  - end_off = (src_off + len) & 3.
  - Go to BUSY.
- **IDLE, cmd_valid, cmd_len = 0:** the command is consumed; no output is produced, no data is consumed, and the FSM stays in IDLE.
- **BUSY:** d_tready = (!m_tvalid || m_tready). Each d handshake does the following:
  - Decrements the counter.
  - Loads the output register with:
    - m_tdata = d_tdata
    - m_tuser = dst_off
    - m_tkeep per the rules below
    - m_tlast = (counter == 1)
- **BUSY → IDLE:** on the d handshake where counter == 1.
- **Lane masks** (big-endian form, bit3 = lowest address; bit-reversed when BIG_ENDIAN ≠ "TRUE"):
  - first-word mask by src_off: 0 → 1111, 1 → 0111, 2 → 0011, 3 → 0001.
  - last-word mask by end_off: 0 → 1111, 1 → 1000, 2 → 1100, 3 → 1110.
  - A single-word packet uses the first mask AND the last mask.
  - Middle words use 1111.
- **Output register:**
  - m_tvalid is set on a d handshake.
  - m_tvalid is cleared on an m handshake with no simultaneous d handshake.
  - All m_* outputs hold while m_tvalid && !m_tready.
- The upstream source supplies exactly `words` dwords per command. Any extra d beats while in IDLE are not accepted (d_tready = 0).

## Timing
- **Reset values:**
  - m_tvalid = 0, m_tlast = 0, m_tkeep = 0, m_tdata = 0, m_tuser = 0.
  - State = IDLE, so cmd_ready = 1.
  - Counter = 0.
- Command acceptance to first d_tready: 1 cycle.
- d handshake to m_tvalid: 1 cycle.
- Throughput: 1 dword per cycle while m_tready = 1.
- One idle cycle between packets, because cmd_ready is low in BUSY, including the cycle in which the last d beat is accepted.
- Simultaneous m handshake and d handshake: the register reloads and m_tvalid stays 1 (no bubble).
- **Backpressure:** with m_tready = 0 and m_tvalid = 1, d_tready = 0 and the counter holds.
- **Reset mid-packet:**
  - The FSM returns to IDLE and the counter clears.
  - m_tvalid deasserts immediately (asynchronous).
  - The partial packet is dropped with no tlast.
- m_tkeep is never 0000 while m_tvalid = 1.

## Test plan
- **Aligned packet:** src_off 0, len 8, dst_off 0, m_tready = 1 → 2 beats, tkeep 1111/1111, tlast on beat 2, m_tuser 0, one-cycle latency.
- **Unaligned, single word:** src_off 1, len 2 → words = 1, one beat with tkeep 0110 and tlast = 1.
- **Unaligned, spanning:** src_off 3, len 6, dst_off 2 → words = 3, tkeep 0001/1111/1000, m_tuser 2 on every beat.
- **Backpressure:** src_off 2, len 64, m_tready toggled 1,0,0,1,…, and also held low for 5 cycles mid-packet → no beat lost or duplicated, d_tready low whenever m_tvalid && !m_tready, 17 beats total, last tkeep 1100.
- **Zero length and back-to-back:** cmd_len 0 followed by len 4 → the zero-length command is consumed with no output; the next packet's first beat follows with tkeep 1111 and tlast = 1; cmd_ready low for exactly the BUSY duration plus one idle cycle.
- **Reset mid-packet and little-endian:** aresetn asserted during beat 3 of a 10-word packet → m_tvalid = 0 and cmd_ready = 1 right after reset; with BIG_ENDIAN = "FALSE", src_off 1, len 2 → m_tkeep 0110, data lanes unchanged.
